// File: rtl/avr_pkg.sv
// Shared opcode constants, FSM encoding and helpers for the fetch/issue front end.
package avr_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned ID_W    = 11;

  localparam logic [3:0] OP_JCR   = 4'b1100;
  localparam logic [3:0] OP_BR    = 4'b1111;
  localparam logic [1:0] SUB_JMP  = 2'b11;
  localparam logic [1:0] SUB_CALL = 2'b01;
  localparam logic [1:0] SUB_RET  = 2'b00;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_EXT    = 3'd2;
  localparam logic [2:0] ST_EXTLD  = 3'd3;
  localparam logic [2:0] ST_DECODE = 3'd4;
  localparam logic [2:0] ST_EXEC   = 3'd5;

  typedef enum logic [2:0] {
    S_FETCH  = ST_FETCH,
    S_LOAD   = ST_LOAD,
    S_EXT    = ST_EXT,
    S_EXTLD  = ST_EXTLD,
    S_DECODE = ST_DECODE,
    S_EXEC   = ST_EXEC
  } state_t;

  // JMP and CALL carry their target in a second word
  function automatic logic is_two_word(input logic [INSTR_W-1:0] w);
    return (w[15:12] == OP_JCR) && ((w[6:5] == SUB_JMP) || (w[6:5] == SUB_CALL));
  endfunction

  function automatic logic is_ret(input logic [INSTR_W-1:0] w);
    return (w[15:12] == OP_JCR) && (w[6:5] == SUB_RET);
  endfunction

  function automatic logic is_branch(input logic [INSTR_W-1:0] w);
    return w[15:12] == OP_BR;
  endfunction

endpackage

// File: rtl/ifu_pc_next.sv
// Next-PC selection: sequential step, RET to lr, JMP/CALL target, or relative branch.
module ifu_pc_next
  import avr_pkg::*;
#(
  parameter int unsigned PC_W = 16
) (
  input  logic [PC_W-1:0]    pc,
  input  logic [PC_W-1:0]    lr,
  input  logic [INSTR_W-1:0] ext_word,
  input  logic [INSTR_W-1:0] ir,
  input  logic               sel_pc_load,
  output logic [PC_W-1:0]    next_pc
);

  logic [PC_W-1:0] len;
  logic [PC_W-1:0] offset;
  logic            unused_ir;

  assign unused_ir = ^ir[11:7];

  // Pick the next PC; all sums wrap modulo 2^PC_W
  always_comb begin
    len     = is_two_word(ir) ? PC_W'(2) : PC_W'(1);
    offset  = {{(PC_W-5){ir[4]}}, ir[4:0]};
    next_pc = pc + len;
    if (sel_pc_load) begin
      if (is_ret(ir)) begin
        next_pc = lr;
      end else if (is_two_word(ir)) begin
        next_pc = ext_word[PC_W-1:0];
      end else if (is_branch(ir)) begin
        next_pc = pc + PC_W'(1) + offset;
      end
    end
  end

endmodule

// File: rtl/instr_fetch_issue.sv
// Fetch/issue front end: reads program memory, holds ir/ext_word, drives the
// decoder enable and updates pc/lr from the decoder's load selects.
module instr_fetch_issue
  import avr_pkg::*;
#(
  parameter int unsigned     PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hold,
  output logic [PC_W-1:0]    pmem_addr,
  output logic               pmem_rd_en,
  input  logic [INSTR_W-1:0] pmem_rdata,
  output logic [ID_W-1:0]    ID,
  output logic               en_dec,
  output logic [INSTR_W-1:0] ir,
  output logic [INSTR_W-1:0] ext_word,
  input  logic               sel_pc_load,
  input  logic               sel_LR_load,
  output logic [PC_W-1:0]    pc,
  output logic [PC_W-1:0]    lr,
  output logic               retire
);

  state_t          state_q, state_d;
  logic [PC_W-1:0] next_pc;

  ifu_pc_next #(.PC_W(PC_W)) u_pc_next (
    .pc          (pc),
    .lr          (lr),
    .ext_word    (ext_word),
    .ir          (ir),
    .sel_pc_load (sel_pc_load),
    .next_pc     (next_pc)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state and state-decoded strobes; no read while reset is asserted
  always_comb begin
    state_d    = state_q;
    pmem_rd_en = 1'b0;
    en_dec     = 1'b0;
    retire     = 1'b0;
    pmem_addr  = pc;
    case (state_q)
      S_FETCH: begin
        if (!hold) begin
          pmem_rd_en = rst_n;
          state_d    = S_LOAD;
        end
      end
      S_LOAD:   state_d = is_two_word(pmem_rdata) ? S_EXT : S_DECODE;
      S_EXT: begin
        pmem_rd_en = rst_n;
        pmem_addr  = pc + PC_W'(1);
        state_d    = S_EXTLD;
      end
      S_EXTLD:  state_d = S_DECODE;
      S_DECODE: begin
        en_dec  = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      default:  state_d = S_FETCH;
    endcase
  end

  assign ID = ir[15:5];

  // Instruction words, PC and link register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      lr       <= '0;
      ir       <= '0;
      ext_word <= '0;
    end else begin
      case (state_q)
        S_LOAD:  ir       <= pmem_rdata;
        S_EXTLD: ext_word <= pmem_rdata;
        S_EXEC: begin
          pc <= next_pc;
          if (sel_LR_load) lr <= pc + PC_W'(2);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_issue.sv
// Self-checking bench: directed vector table, reset-abort sequence and
// randomized instructions against a next-PC reference model.
module tb_instr_fetch_issue;

  localparam logic [15:0] RST_PC = 16'h0010;

  logic        clk = 1'b0;
  logic        rst_n, hold, sel_pc_load, sel_LR_load;
  logic [15:0] pmem_addr, pmem_rdata, ir, ext_word, pc, lr;
  logic        pmem_rd_en, en_dec, retire;
  logic [10:0] ID;

  logic [15:0] mem [0:65535];
  logic [15:0] pc_m, lr_m;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] word;
    logic [15:0] ext;
    logic        ld;
    logic        lrl;
    int          nhold;
    logic [15:0] exp_pc;
    logic [15:0] exp_lr;
    int          exp_lat;
  } vec_t;

  vec_t tbl [17];

  instr_fetch_issue #(.PC_W(16), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .pmem_addr(pmem_addr),
    .pmem_rd_en(pmem_rd_en), .pmem_rdata(pmem_rdata), .ID(ID), .en_dec(en_dec),
    .ir(ir), .ext_word(ext_word), .sel_pc_load(sel_pc_load),
    .sel_LR_load(sel_LR_load), .pc(pc), .lr(lr), .retire(retire)
  );

  always #5 clk = ~clk;

  // Synchronous program memory: data one cycle after the read strobe
  always @(posedge clk) if (pmem_rd_en) pmem_rdata <= mem[pmem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_pc"}, pc, RST_PC);
    check({tag, "_addr"}, pmem_addr, RST_PC);
    check({tag, "_lr"}, lr, 0);
    check({tag, "_ir"}, ir, 0);
    check({tag, "_ext"}, ext_word, 0);
    check({tag, "_id"}, ID, 0);
    check({tag, "_rd_en"}, pmem_rd_en, 0);
    check({tag, "_en_dec"}, en_dec, 0);
    check({tag, "_retire"}, retire, 0);
  endtask

  // Run one instruction from S_FETCH; called at a negedge with the DUT held in fetch
  task automatic exec_one(input logic [15:0] w, input logic [15:0] ext, input logic ld,
                          input logic lrl, input int nhold, input logic [15:0] e_pc,
                          input logic [15:0] e_lr, input int e_lat);
    int cyc;
    logic done, two;
    logic [15:0] a1;
    a1 = pc_m + 16'd1;
    mem[pc_m] = w;
    mem[a1] = ext;
    two = (w[15:12] == 4'hC) && (w[6:5] == 2'b11 || w[6:5] == 2'b01);
    for (int h = 0; h < nhold; h++) begin
      hold = 1'b1;
      sel_pc_load = 1'($urandom);
      sel_LR_load = 1'($urandom);
      #1;
      check("hold_rd_en", pmem_rd_en, 0);
      check("hold_pc", pc, pc_m);
      @(negedge clk);
    end
    hold = 1'b0;
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < 20) begin
      cyc++;
      if (cyc > 1) hold = 1'($urandom);
      sel_pc_load = 1'($urandom);
      sel_LR_load = 1'($urandom);
      #1;
      if (cyc == 1) begin
        check("fetch_rd_en", pmem_rd_en, 1);
        check("fetch_addr", pmem_addr, pc_m);
      end
      if (cyc == 3 && two) begin
        check("ext_rd_en", pmem_rd_en, 1);
        check("ext_addr", pmem_addr, a1);
      end
      if (en_dec) begin
        check("dec_id", ID, {5'd0, w[15:5]});
        check("dec_ir", ir, w);
        if (two) check("dec_ext", ext_word, ext);
      end
      if (retire) begin
        sel_pc_load = ld;
        sel_LR_load = lrl;
        hold = 1'b1;
        done = 1'b1;
      end
      @(negedge clk);
    end
    hold = 1'b1;
    check("retire_seen", done, 1);
    check("latency", cyc, e_lat);
    #1;
    check("next_pc", pc, e_pc);
    check("next_lr", lr, e_lr);
    check("idle_rd_en", pmem_rd_en, 0);
    @(negedge clk);
    pc_m = e_pc;
    lr_m = e_lr;
  endtask

  // Reference model of one instruction's effect on pc/lr
  task automatic model(input logic [15:0] w, input logic [15:0] ext, input logic ld,
                       input logic lrl, output logic [15:0] npc, output logic [15:0] nlr,
                       output int lat);
    bit two, ret, br;
    int off;
    two = (w[15:12] == 4'hC) && (w[6:5] == 2'b11 || w[6:5] == 2'b01);
    ret = (w[15:12] == 4'hC) && (w[6:5] == 2'b00);
    br  = (w[15:12] == 4'hF);
    off = w[4] ? int'(w[4:0]) - 32 : int'(w[4:0]);
    lat = two ? 6 : 4;
    if (!ld)     npc = 16'(int'(pc_m) + (two ? 2 : 1));
    else if (ret) npc = lr_m;
    else if (two) npc = ext;
    else if (br)  npc = 16'(int'(pc_m) + 1 + off);
    else          npc = 16'(int'(pc_m) + 1);
    nlr = lrl ? 16'(int'(pc_m) + 2) : lr_m;
  endtask

  initial begin
    logic [15:0] w, ext, npc, nlr;
    logic ld, lrl;
    int lat;

    tbl[0]  = '{16'h0000, 16'h0000, 1'b0, 1'b0, 0, 16'h0011, 16'h0000, 4};
    tbl[1]  = '{16'h0000, 16'h0000, 1'b0, 1'b0, 3, 16'h0012, 16'h0000, 4};
    tbl[2]  = '{16'h0000, 16'h0000, 1'b0, 1'b0, 0, 16'h0013, 16'h0000, 4};
    tbl[3]  = '{16'hC060, 16'h0040, 1'b1, 1'b0, 0, 16'h0040, 16'h0000, 6};
    tbl[4]  = '{16'hC020, 16'h0300, 1'b1, 1'b1, 0, 16'h0300, 16'h0042, 6};
    tbl[5]  = '{16'hC000, 16'h0000, 1'b1, 1'b0, 0, 16'h0042, 16'h0042, 4};
    tbl[6]  = '{16'hC060, 16'h0005, 1'b1, 1'b0, 0, 16'h0005, 16'h0042, 6};
    tbl[7]  = '{16'hF01E, 16'h0000, 1'b1, 1'b0, 0, 16'h0004, 16'h0042, 4};
    tbl[8]  = '{16'hC060, 16'h0005, 1'b1, 1'b0, 0, 16'h0005, 16'h0042, 6};
    tbl[9]  = '{16'hF01E, 16'h0000, 1'b0, 1'b0, 0, 16'h0006, 16'h0042, 4};
    tbl[10] = '{16'hC060, 16'hFFFF, 1'b1, 1'b0, 0, 16'hFFFF, 16'h0042, 6};
    tbl[11] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 0, 16'h0000, 16'h0042, 4};
    tbl[12] = '{16'hC060, 16'hFFFE, 1'b1, 1'b0, 0, 16'hFFFE, 16'h0042, 6};
    tbl[13] = '{16'hF003, 16'h0000, 1'b1, 1'b0, 0, 16'h0002, 16'h0042, 4};
    tbl[14] = '{16'hC000, 16'h0000, 1'b1, 1'b1, 0, 16'h0042, 16'h0004, 4};
    tbl[15] = '{16'hC000, 16'h0000, 1'b1, 1'b0, 0, 16'h0004, 16'h0004, 4};
    tbl[16] = '{16'hC020, 16'h1111, 1'b0, 1'b0, 0, 16'h0006, 16'h0004, 6};

    rst_n = 1'b0;
    hold = 1'b0;
    sel_pc_load = 1'b0;
    sel_LR_load = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    reset_checks("reset");
    @(negedge clk);
    rst_n = 1'b1;
    pc_m = RST_PC;
    lr_m = 16'h0000;

    for (int i = 0; i < 17; i++)
      exec_one(tbl[i].word, tbl[i].ext, tbl[i].ld, tbl[i].lrl, tbl[i].nhold,
               tbl[i].exp_pc, tbl[i].exp_lr, tbl[i].exp_lat);

    // Reset asserted while the second word of a JMP is being loaded
    mem[pc_m] = 16'hC060;
    mem[16'(pc_m + 16'd1)] = 16'h1234;
    hold = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    reset_checks("extld_reset");
    @(negedge clk);
    rst_n = 1'b1;
    pc_m = RST_PC;
    lr_m = 16'h0000;
    exec_one(16'h0000, 16'h0000, 1'b0, 1'b0, 0, 16'h0011, 16'h0000, 4);

    // Randomized instruction mix against the reference model
    for (int n = 0; n < 200; n++) begin
      ext = 16'($urandom);
      case ($urandom_range(0, 4))
        0:       w = 16'($urandom);
        1:       w = {4'hC, 5'($urandom), 2'b11, 5'($urandom)};
        2:       w = {4'hC, 5'($urandom), 2'b01, 5'($urandom)};
        3:       w = {4'hC, 5'($urandom), 2'b00, 5'($urandom)};
        default: w = {4'hF, 7'($urandom), 5'($urandom)};
      endcase
      ld  = 1'($urandom);
      lrl = 1'($urandom);
      model(w, ext, ld, lrl, npc, nlr, lat);
      exec_one(w, ext, ld, lrl, ($urandom_range(0, 7) == 0) ? 2 : 0, npc, nlr, lat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
